seg_value_fmt: RTL and testbench
================================

// Module: seg_value_fmt
// PURPOSE
//  Upstream feeder of the 6-digit dynamic seg display driver. Accepts a stream of signed
//  binary samples, averages 2^AVG_LOG2 of them, splits sign/magnitude, saturates to what
//  the display can show and rate-limits updates so digits do not flicker. Drives the
//  display's data/point/sign/seg_en inputs directly.
// PARAMETERS
//  DIN_W      24       sample width, two's complement
//  AVG_LOG2   3        log2 of samples per average (8)
//  CNT_1MS    49_999   clk cycles per 1 ms minus 1 (50 MHz)
//  UPDATE_MS  200      display refresh period in ms
//  POINT_POS  2        digit index (0..5) carrying the fixed decimal point
// PORTS
//  clk        in   1      system clock, 50 MHz
//  rstn       in   1      asynchronous reset, active-low
//  din        in   DIN_W  signed sample
//  din_valid  in   1      sample present
//  din_ready  out  1      sample accepted when din_valid & din_ready
//  hold       in   1      1 = freeze display contents
//  data       out  20     magnitude to display, 0..999_999
//  point      out  6      one-hot decimal point, active-high
//  sign       out  1      1 = negative (display shows minus on digit 5)
//  seg_en     out  1      display enable
//  ovf        out  1      displayed value was saturated
// BEHAVIOUR
//  Reset (async, rstn=0): data=0, point=0, sign=0, seg_en=0, ovf=0, accumulator/sample
//   count/ms counters/res_valid cleared, FSM=ACC; din_ready=1 from first edge after release.
//  FSM ACC -> DIV -> ABS -> SAT -> ACC, one cycle each outside ACC; din_ready=1 only in ACC.
//  ACC: each handshake adds sign-extended din to acc (DIN_W+AVG_LOG2 bits), count++.
//   On the 2^AVG_LOG2-th accepted sample, acc/count restart next use; FSM -> DIV.
//  DIV: avg = acc >>> AVG_LOG2 (arithmetic, floor toward -inf), truncated to DIN_W.
//  ABS: sign_n = avg[MSB]; mag = sign_n ? -avg : avg (DIN_W unsigned; -2^(DIN_W-1) ok).
//  SAT: positive mag>999_999 -> 999_999, ovf_n=1; negative mag>99_999 -> 99_999,
//   ovf_n=1 (digit 5 holds minus). Result into res_* regs, res_valid=1.
//   Newer result overwrites an undisplayed one.
//  Latency: last accepted sample -> res_valid high = 4 cycles.
//  Tick: ms counter wraps at CNT_1MS; update counter wraps at UPDATE_MS-1, pulses upd_tick
//   1 cycle per UPDATE_MS ms, free-running, unaffected by hold.
//  On upd_tick & res_valid & !hold: data/sign/ovf <= res_*, point <= 1<<POINT_POS,
//   seg_en <= 1, res_valid <= 0. Without res_valid or with hold: outputs unchanged.
//  Simultaneous SAT write and upd_tick: tick displays old res_*; res_valid ends 1 (set wins).
//  seg_en stays 0 until first update, then 1 until reset. All outputs registered.
//  Reset mid-average discards partial sums; no partial average ever displayed.
// STRUCTURE
//  Shared include seg_defs.vh: SEG_DIGITS=6, SEG_MAX_POS=20'd999_999,
//   SEG_MAX_NEG=20'd99_999, FSM state encodings.
//  One sub-module: seg_upd_tick (ms counter + period counter -> 1-cycle upd_tick).
//  Averaging FSM and output registers stay in this module.
// TESTING (sim params CNT_1MS=9, UPDATE_MS=2, AVG_LOG2=3, POINT_POS=2)
//  Reset, no input -> data=0, point=0, sign=0, seg_en=0, ovf=0, din_ready=1; 3 ticks later still 0.
//  8 x din=1234 -> after next upd_tick data=1234, sign=0, point=6'b000100, seg_en=1, ovf=0.
//  4 x -5 and 4 x -6 (sum -44) -> data=6, sign=1 (floor of -5.5).
//  8 x 2_000_000 -> data=999_999, ovf=1; then 8 x -150_000 -> data=99_999, sign=1, ovf=1.
//  hold=1 across tick with result pending -> outputs unchanged; hold=0 -> next tick shows latest.
//  din_valid held 1 -> din_ready low exactly 3 cycles per 8 accepts; rstn pulse after 5 -> seg_en=0,
//   next 8 samples of 7 display data=7.

Source files
------------

// File: rtl/seg_value_fmt_pkg.sv
// Shared display constants and averaging FSM state encoding for seg_value_fmt.
package seg_value_fmt_pkg;
   localparam int          SEG_DIGITS  = 6;
   localparam logic [19:0] SEG_MAX_POS = 20'd999_999;
   localparam logic [19:0] SEG_MAX_NEG = 20'd99_999;

   typedef enum logic [1:0] {
      ST_ACC = 2'd0,
      ST_DIV = 2'd1,
      ST_ABS = 2'd2,
      ST_SAT = 2'd3
   } fsm_state_e;
endpackage

// File: rtl/seg_value_fmt_upd_tick.sv
// Free-running ms prescaler plus period counter; emits a 1-cycle upd_tick once per period.
module seg_upd_tick #(
   parameter int CNT_1MS   = 49_999,
   parameter int UPDATE_MS = 200
) (
   input  logic clk,
   input  logic rstn,
   output logic upd_tick
);
   localparam int MS_W  = $clog2(CNT_1MS + 1) < 1 ? 1 : $clog2(CNT_1MS + 1);
   localparam int UPD_W = $clog2(UPDATE_MS + 1);

   logic [MS_W-1:0]  ms_cnt;
   logic [UPD_W-1:0] upd_cnt;
   logic             ms_wrap;

   assign ms_wrap = (ms_cnt == MS_W'(CNT_1MS));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ms_cnt   <= '0;
         upd_cnt  <= '0;
         upd_tick <= 1'b0;
      end else begin
         ms_cnt   <= ms_wrap ? '0 : ms_cnt + 1'b1;
         upd_tick <= ms_wrap && (upd_cnt == UPD_W'(UPDATE_MS - 1));
         if (ms_wrap)
            upd_cnt <= (upd_cnt == UPD_W'(UPDATE_MS - 1)) ? '0 : upd_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/seg_value_fmt.sv
// Averages signed samples, converts to saturated sign/magnitude and pushes the
// result to the 6-digit seg display at a fixed, flicker-free refresh rate.
module seg_value_fmt
   import seg_value_fmt_pkg::*;
#(
   parameter int DIN_W     = 24,
   parameter int AVG_LOG2  = 3,
   parameter int CNT_1MS   = 49_999,
   parameter int UPDATE_MS = 200,
   parameter int POINT_POS = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DIN_W-1:0]      din,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic                  hold,
   output logic [19:0]           data,
   output logic [SEG_DIGITS-1:0] point,
   output logic                  sign,
   output logic                  seg_en,
   output logic                  ovf
);
   localparam int ACC_W = DIN_W + AVG_LOG2;

   fsm_state_e          state, state_n;
   logic [AVG_LOG2-1:0] cnt;
   logic [ACC_W-1:0]    acc;
   logic [DIN_W-1:0]    avg;
   logic [DIN_W-1:0]    mag;
   logic                sign_n;
   logic [19:0]         res_data;
   logic                res_sign, res_ovf, res_valid;
   logic                upd_tick, take, show;

   assign take = din_valid & din_ready;
   assign show = upd_tick & res_valid & ~hold;

   seg_upd_tick #(.CNT_1MS(CNT_1MS), .UPDATE_MS(UPDATE_MS)) u_tick (
      .clk     (clk),
      .rstn    (rstn),
      .upd_tick(upd_tick)
   );

   always_comb begin
      state_n = state;
      case (state)
         ST_ACC:  if (take && cnt == '1) state_n = ST_DIV;
         ST_DIV:  state_n = ST_ABS;
         ST_ABS:  state_n = ST_SAT;
         default: state_n = ST_ACC;
      endcase
   end

   // cnt==0 on a take means a fresh average: the old sum is dropped, not added.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= ST_ACC;
         din_ready <= 1'b0;
         cnt       <= '0;
         acc       <= '0;
         avg       <= '0;
         mag       <= '0;
         sign_n    <= 1'b0;
      end else begin
         state     <= state_n;
         din_ready <= (state_n == ST_ACC);
         if (take) begin
            acc <= ((cnt == '0) ? '0 : acc) + {{AVG_LOG2{din[DIN_W-1]}}, din};
            cnt <= cnt + 1'b1;
         end
         // Upper DIN_W bits of acc are exactly acc >>> AVG_LOG2 truncated.
         if (state == ST_DIV) avg <= acc[ACC_W-1:AVG_LOG2];
         if (state == ST_ABS) begin
            sign_n <= avg[DIN_W-1];
            mag    <= avg[DIN_W-1] ? (~avg + 1'b1) : avg;
         end
      end
   end

   // Negative values lose digit 5 to the minus sign, hence the lower ceiling.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_data  <= '0;
         res_sign  <= 1'b0;
         res_ovf   <= 1'b0;
         res_valid <= 1'b0;
      end else if (state == ST_SAT) begin
         res_sign  <= sign_n;
         res_valid <= 1'b1;
         if (sign_n && mag > DIN_W'(SEG_MAX_NEG)) begin
            res_data <= SEG_MAX_NEG;
            res_ovf  <= 1'b1;
         end else if (!sign_n && mag > DIN_W'(SEG_MAX_POS)) begin
            res_data <= SEG_MAX_POS;
            res_ovf  <= 1'b1;
         end else begin
            res_data <= mag[19:0];
            res_ovf  <= 1'b0;
         end
      end else if (show) begin
         res_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data   <= '0;
         point  <= '0;
         sign   <= 1'b0;
         seg_en <= 1'b0;
         ovf    <= 1'b0;
      end else if (show) begin
         data   <= res_data;
         sign   <= res_sign;
         ovf    <= res_ovf;
         point  <= SEG_DIGITS'(1) << POINT_POS;
         seg_en <= 1'b1;
      end
   end
endmodule

// File: tb/tb_seg_value_fmt.sv
// Randomized and directed checks of seg_value_fmt against an arithmetic reference model.
module tb_seg_value_fmt;
   localparam int DIN_W = 24;
   localparam int WAIT_SHOW = 45; // > 2 refresh periods of 20 cycles

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic [DIN_W-1:0]  din = '0;
   logic              din_valid = 1'b0;
   logic              din_ready;
   logic              hold = 1'b0;
   logic [19:0]       data;
   logic [5:0]        point;
   logic              sign, seg_en, ovf;

   int n_checks = 0;
   int n_fail   = 0;

   seg_value_fmt #(
      .DIN_W(DIN_W), .AVG_LOG2(3), .CNT_1MS(9), .UPDATE_MS(2), .POINT_POS(2)
   ) dut (
      .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .hold(hold), .data(data), .point(point), .sign(sign), .seg_en(seg_en), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input int v);
      int n = 0;
      din       = DIN_W'(v);
      din_valid = 1'b1;
      while (!din_ready && n < 50) begin cycles(1); n++; end
      if (n >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL push_timeout: din_ready stayed %0b, required 1", din_ready);
      end
      cycles(1);
      din_valid = 1'b0;
   endtask

   // Reference: floor average, sign/magnitude, display-limited saturation.
   function automatic logic [22:0] model(input longint sum);
      longint a, m;
      logic s, o;
      a = (sum >= 0) ? sum / 8 : -((-sum + 7) / 8);
      s = (a < 0);
      m = s ? -a : a;
      o = 1'b0;
      if (s && m > 99_999) begin m = 99_999; o = 1'b1; end
      if (!s && m > 999_999) begin m = 999_999; o = 1'b1; end
      return {s, o, 1'b1, 20'(m)}; // {sign, ovf, seg_en, data}
   endfunction

   task automatic test_reset();
      rstn = 1'b0;
      cycles(3);
      rstn = 1'b1;
      cycles(2);
      n_checks++;
      if ({data, point, sign, seg_en, ovf} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%0d point=%b sign=%b seg_en=%b ovf=%b, required all 0",
                  data, point, sign, seg_en, ovf);
      end
      n_checks++;
      if (din_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b, required 1", din_ready);
      end
      cycles(65);
      n_checks++;
      if ({data, point, sign, seg_en, ovf} !== 29'd0) begin
         n_fail++;
         $display("FAIL idle_ticks: got data=%0d point=%b seg_en=%b, required all 0", data, point, seg_en);
      end
   endtask

   task automatic test_basic();
      repeat (8) push(1234);
      cycles(WAIT_SHOW);
      n_checks++;
      if ({data, sign, seg_en, ovf, point} !== {20'd1234, 3'b010, 6'b000100}) begin
         n_fail++;
         $display("FAIL basic_1234: got data=%0d sign=%b seg_en=%b ovf=%b point=%b, required 1234 0 1 0 000100",
                  data, sign, seg_en, ovf, point);
      end
   endtask

   task automatic test_floor();
      repeat (4) push(-5);
      repeat (4) push(-6);
      cycles(WAIT_SHOW);
      n_checks++;
      if ({sign, ovf, data} !== {2'b10, 20'd6}) begin
         n_fail++;
         $display("FAIL floor_neg: got data=%0d sign=%b ovf=%b, required 6 1 0", data, sign, ovf);
      end
   endtask

   task automatic test_saturate();
      repeat (8) push(2_000_000);
      cycles(WAIT_SHOW);
      n_checks++;
      if ({sign, ovf, data} !== {2'b01, 20'd999_999}) begin
         n_fail++;
         $display("FAIL sat_pos: got data=%0d sign=%b ovf=%b, required 999999 0 1", data, sign, ovf);
      end
      repeat (8) push(-150_000);
      cycles(WAIT_SHOW);
      n_checks++;
      if ({sign, ovf, data} !== {2'b11, 20'd99_999}) begin
         n_fail++;
         $display("FAIL sat_neg: got data=%0d sign=%b ovf=%b, required 99999 1 1", data, sign, ovf);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         longint sum = 0;
         logic [22:0] exp_v;
         for (int i = 0; i < 8; i++) begin
            int v;
            case (r % 3)
               0: v = int'($urandom_range(4000)) - 2000;
               1: v = int'($urandom_range(2_400_000)) - 1_200_000;
               default: v = int'({{8{1'b0}}, 24'($urandom)}) - (1 << 23);
            endcase
            sum += longint'(v);
            push(v);
         end
         exp_v = model(sum);
         cycles(WAIT_SHOW);
         n_checks++;
         if ({sign, ovf, seg_en, data} !== exp_v || point !== 6'b000100) begin
            n_fail++;
            $display("FAIL random_%0d: got sign=%b ovf=%b seg_en=%b data=%0d point=%b, required sign=%b ovf=%b data=%0d point=000100",
                     r, sign, ovf, seg_en, data, point, exp_v[22], exp_v[21], exp_v[19:0]);
         end
      end
   endtask

   task automatic test_hold();
      repeat (8) push(4321);
      cycles(WAIT_SHOW);
      hold = 1'b1;
      repeat (8) push(-777);
      repeat (8) push(55_555);
      cycles(WAIT_SHOW);
      n_checks++;
      if ({sign, ovf, data} !== {2'b00, 20'd4321}) begin
         n_fail++;
         $display("FAIL hold_frozen: got data=%0d sign=%b, required 4321 0", data, sign);
      end
      hold = 1'b0;
      cycles(WAIT_SHOW);
      n_checks++;
      if ({sign, ovf, data} !== {2'b00, 20'd55_555}) begin
         n_fail++;
         $display("FAIL hold_release: got data=%0d sign=%b, required latest 55555 0", data, sign);
      end
   endtask

   task automatic test_back_to_back();
      int acc_n = 0, low = 0, cyc = 0;
      din = DIN_W'(9);
      din_valid = 1'b1;
      while (acc_n < 16 && cyc < 200) begin
         if (din_ready) acc_n++; else if (acc_n > 0) low++;
         cycles(1);
         cyc++;
      end
      din_valid = 1'b0;
      n_checks++;
      if (acc_n != 16 || low != 3) begin
         n_fail++;
         $display("FAIL b2b_ready: got %0d accepts with %0d not-ready cycles, required 16 and 3", acc_n, low);
      end
      cycles(WAIT_SHOW);
      n_checks++;
      if ({sign, ovf, data} !== {2'b00, 20'd9}) begin
         n_fail++; $display("FAIL b2b_data: got data=%0d, required 9", data);
      end
      repeat (5) push(500_000);
      rstn = 1'b0;
      cycles(2);
      n_checks++;
      if (seg_en !== 1'b0 || data !== 20'd0) begin
         n_fail++; $display("FAIL midreset: got seg_en=%b data=%0d, required 0 0", seg_en, data);
      end
      rstn = 1'b1;
      cycles(2);
      repeat (8) push(7);
      cycles(WAIT_SHOW);
      n_checks++;
      if ({sign, ovf, seg_en, data} !== {3'b001, 20'd7}) begin
         n_fail++;
         $display("FAIL after_reset: got data=%0d seg_en=%b ovf=%b, required 7 1 0", data, seg_en, ovf);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_floor();
      test_saturate();
      test_random();
      test_hold();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
